// File: rtl/nsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nsa_pkg
// Description : Shared definitions for the nibble-serial adder controller:
//               FSM state encoding, nibble width and the index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nsa_pkg;

    // Bits handled by the shared add/P-G slice per step
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index n nibbles; never less than 1 so a counter exists
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nsa_nibble_slice.sv
`default_nettype none
// ============================================================================
// Module      : nsa_nibble_slice
// Description : Combinational 4-bit add slice with group generate/propagate.
//               g is the carry-out the nibble would produce with carry-in 0,
//               p is high when every bit pair propagates.
// Ports       : a, b  - nibble operands
//               c     - carry-in
//               s     - nibble sum
//               c4    - carry-out
//               g, p  - nibble group generate / propagate
// Revision    : 1.0 - initial release
// ============================================================================
module nsa_nibble_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] s,
    output logic       c4,
    output logic       g,
    output logic       p
);

    logic [4:0] w_raw;

    assign w_raw = {1'b0, a} + {1'b0, b};
    assign g     = w_raw[4];
    assign p     = &(a ^ b);
    // A nibble carries out if it generates, or propagates an incoming carry
    assign c4    = g | (p & c);
    assign s     = w_raw[3:0] + {3'b000, c};

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Adds two WIDTH-bit operands one nibble per clock through a
//               single shared 4-bit slice, LS nibble first. The carry ripples
//               through a register and the word-level group generate and
//               propagate are accumulated as a lookahead unit would form them.
//               Start/done handshake; results hold until the next operation.
// Ports       : clk, rst_n       - clock, async active-low reset
//               start            - request, sampled only while ready
//               a, b, cin        - operands and carry-in, latched on accept
//               ready/busy/done  - IDLE / RUN+DONE / one-cycle result pulse
//               sum, cout        - registered result
//               gg, pp           - word group generate / propagate
// Option      : NIBBLE_SERIAL_SUB_EN adds input sub (a-b when set) and output
//               ovf (signed overflow of the final result).
// Parameters  : WIDTH must be a multiple of 4 and at least 8.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             gg,
    output logic             pp
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = clog2(NIB);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               gg_q,    gg_d;
    logic               pp_q,    pp_d;
    logic               gacc_q,  gacc_d;
    logic               pacc_q,  pacc_d;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic               ovf_q,   ovf_d;
`endif

    logic [IDX_W+1:0]   w_bit_base;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_s_nib;
    logic               w_c4;
    logic               w_g;
    logic               w_p;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_c_init;

    // Bit offset of the current nibble (idx * 4)
    assign w_bit_base = {idx_q, 2'b00};
    assign w_a_nib    = a_q[w_bit_base +: NIB_W];
    assign w_b_nib    = b_q[w_bit_base +: NIB_W];

    nsa_nibble_slice u_slice (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .c  (carry_q),
        .s  (w_s_nib),
        .c4 (w_c4),
        .g  (w_g),
        .p  (w_p)
    );

    // Operand B and initial carry as seen by the slice; subtraction is
    // a + ~b + 1, so cin is disregarded in that mode.
`ifdef NIBBLE_SERIAL_SUB_EN
    assign w_b_eff  = sub ? ~b : b;
    assign w_c_init = sub ? 1'b1 : cin;
`else
    assign w_b_eff  = b;
    assign w_c_init = cin;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        gg_d    = gg_q;
        pp_d    = pp_q;
        gacc_d  = gacc_q;
        pacc_d  = pacc_q;
`ifdef NIBBLE_SERIAL_SUB_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = w_b_eff;
                    carry_d = w_c_init;
                    sum_d   = '0;
                    idx_d   = '0;
                    // Identity values for the G/P reduction
                    gacc_d  = 1'b0;
                    pacc_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[w_bit_base +: NIB_W] = w_s_nib;
                carry_d = w_c4;
                // Higher nibble's generate wins; lower generate survives only
                // if this nibble propagates it.
                gacc_d  = w_g | (w_p & gacc_q);
                pacc_d  = pacc_q & w_p;
                idx_d   = idx_q + 1'b1;
                if (idx_q == C_IDX_LAST) begin
                    cout_d  = w_c4;
                    gg_d    = gacc_d;
                    pp_d    = pacc_d;
`ifdef NIBBLE_SERIAL_SUB_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            gg_q    <= 1'b0;
            pp_q    <= 1'b0;
            gacc_q  <= 1'b0;
            pacc_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            gg_q    <= gg_d;
            pp_q    <= pp_d;
            gacc_q  <= gacc_d;
            pacc_q  <= pacc_d;
`ifdef NIBBLE_SERIAL_SUB_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign gg    = gg_q;
    assign pp    = pp_q;
`ifdef NIBBLE_SERIAL_SUB_EN
    assign ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-cycle controller that reuses one 4-bit add/P-G slice to add two WIDTH-bit operands, one nibble per clock, starting from the least significant nibble.
It ripples the carry between nibbles in a register and accumulates the whole-word group generate and propagate, the same way a lookahead unit would combine them.
It sits in front of the lookahead adder group as a low-area alternative and uses a start/done handshake.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
NIB, WIDTH/4, number of nibble steps; derived, not overridable.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only while ready=1.
a  input  WIDTH  operand A; latched on the accepted start.
b  input  WIDTH  operand B; latched on the accepted start.
cin  input  1  carry-in; latched on the accepted start.
ready  output  1  high in IDLE only.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; results are valid.
sum  output  WIDTH  registered sum.
cout  output  1  registered carry-out.
gg  output  1  word group generate: OR over i of (G_i AND P_j for all j>i).
pp  output  1  word group propagate: AND of all nibble P_i.

Behaviour:
- Clock and reset are decided: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, gg=0, pp=0, nibble index=0, carry register=0.
- States and transitions:
  - IDLE -> RUN on an edge with start=1. That edge latches a, b and cin, clears sum, sets index=0, gacc=0 and pacc=1.
  - RUN, each edge: the slice adds a_nib[idx] + b_nib[idx] + carry.
    - Writes sum[4*idx+3:4*idx] and updates carry to the slice carry-out.
    - Updates gacc = G_idx | (P_idx & gacc) and pacc = pacc & P_idx.
    - Increments idx.
  - RUN -> DONE on the edge that processes idx=NIB-1. That edge also loads cout=carry-out, gg=new gacc and pp=new pacc.
  - DONE -> IDLE unconditionally after one cycle. done=1 only during DONE.
- Latency: start accepted at edge k; done is high between edges k+NIB and k+NIB+1. ready returns at edge k+NIB+1.
- Slice rules:
  - G = c4 computed with carry-in 0.
  - P = AND of (a_i XOR b_i) over the nibble.
  - gg and pp are independent of cin. cout is not.
- start while busy is ignored, including during DONE. Input changes after acceptance have no effect.
- sum, cout, gg and pp hold after DONE until the next accepted start clears sum; cout, gg and pp are overwritten at the end of the next operation.
- Reset mid-operation aborts immediately and returns every output to its reset value. No done is produced.
- Overflow beyond WIDTH is reported only via cout. sum wraps modulo 2^WIDTH.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- With it defined:
  - Adds input port sub (1 bit), latched on the accepted start.
  - When sub=1, the latched B is ~b and the initial carry is 1, so sum=a-b. cin is ignored.
  - Adds output port ovf, reset 0, loaded in DONE with signed overflow: (a_msb==b_eff_msb) && (sum_msb!=a_msb).
- Without it: no sub or ovf ports. Behaviour is add-only as above.

Decomposition:
- Shared package/include file nsa_pkg holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the nibble width constant 4;
  - the index-width function clog2(NIB).
- One natural sub-module, nsa_nibble_slice: combinational 4-bit a, b, c in -> s[3:0], c4, G, P.
- The FSM, index counter, carry register and G/P accumulators stay in the top module.

Test Plan:
- Basic add, WIDTH=16: a=16'h00FF, b=16'h0001, cin=0 -> sum=16'h0100, cout=0, gg=0, pp=0. done pulses exactly 4 cycles after the start edge.
- Generate chain: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, gg=1, pp=0.
- Full propagate: a=16'hAAAA, b=16'h5555, cin=1 -> sum=16'h0000, cout=1, gg=0, pp=1. Repeat with cin=0 -> sum=16'hFFFF, cout=0, gg=0, pp=1.
- Handshake:
  - Hold start=1 continuously -> operations accepted every NIB+2 cycles.
  - start pulses during RUN and DONE are ignored.
  - Changing a and b mid-RUN leaves the result unchanged.
- Reset abort: assert rst_n=0 asynchronously at nibble 2 -> all outputs 0 immediately and no done. After release, start with 16'h1234+16'h4321 -> sum=16'h5555, cout=0.
- With NIBBLE_SERIAL_SUB_EN:
  - a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, ovf=1, cout=1.
  - a=16'h0005, b=16'h0003, sub=1 -> sum=16'h0002, ovf=0.
